fd_pipe_reg: RTL

- Fetch→Decode pipeline register of the 5-stage MIPS core with precise exceptions and interrupts.
- Captures the fetched PC and instruction together with the fetch-stage exception status (AdEL) and the branch-delay-slot flag.
- Supports three control actions on these values: hold on a hazard stall, flush to a handler bubble on an exception/interrupt request (req), and replace faulting instructions with a NOP.
- Drives the D-stage decoder, the hazard unit and the exception pipeline that feeds CP0.

---
 rtl/fd_pipe_reg_pkg.sv | 35 +++
 rtl/fd_pipe_reg.sv | 62 ++++++
 2 files changed

// File: rtl/fd_pipe_reg_pkg.sv
// Shared pipeline constants and types for the MIPS core's pipeline registers and CP0.
// The F/D, D/E, E/M and M/W registers all import this package.
package fd_pipe_reg_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } fd_stage_t;

    // A bubble keeps a meaningful PC so CP0 always sees a defined macro-PC.
    function automatic fd_stage_t make_bubble(input logic [31:0] pc, input logic [31:0] nop);
        fd_stage_t s;
        s.pc      = pc;
        s.instr   = nop;
        s.exccode = EXC_NONE;
        s.bd      = 1'b0;
        s.valid   = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// Fetch->Decode pipeline register: captures PC, instruction, fetch AdEL status and delay-slot flag,
// with stall hold, exception-request flush to a handler bubble, and NOP substitution on faulting fetches.
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = fd_pipe_reg_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = fd_pipe_reg_pkg::HANDLER_PC,
    parameter logic [31:0] NOP_INSTR  = fd_pipe_reg_pkg::NOP_INSTR,
    parameter logic [4:0]  EXC_ADEL   = fd_pipe_reg_pkg::EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        F_excAdEL,
    input  logic        F_bd,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid
);

    fd_stage_t stage_q;
    fd_stage_t stage_d;

    // F-side inputs are only consulted on a normal load, so X on them under stall/req never reaches D.
    always_comb begin
        stage_d = stage_q;
        if (req) begin
            stage_d = make_bubble(HANDLER_PC, NOP_INSTR);
        end else if (!stall) begin
            stage_d.pc    = F_pc;
            stage_d.bd    = F_bd;
            stage_d.valid = 1'b1;
            if (F_excAdEL) begin
                stage_d.instr   = NOP_INSTR;
                stage_d.exccode = EXC_ADEL;
            end else begin
                stage_d.instr   = F_instr;
                stage_d.exccode = EXC_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= make_bubble(RESET_PC, NOP_INSTR);
        end else begin
            stage_q <= stage_d;
        end
    end

    assign D_pc      = stage_q.pc;
    assign D_instr   = stage_q.instr;
    assign D_exccode = stage_q.exccode;
    assign D_bd      = stage_q.bd;
    assign D_valid   = stage_q.valid;

endmodule
